// File: rtl/vga_rect_loader.sv
// Host-side batch scheduler: buffers rectangle writes in a FIFO and replays each committed batch during vblank.
// Optional commit statistics counter (ld__commits) is enabled by defining VGA_LOADER_STATS_EN.
module vga_rect_loader #(
  parameter int RECTBITS  = 6,
  parameter int DEPTH     = 8,
  parameter int DEPTHBITS = 3
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                hw__valid,
  output logic                hw__ready,
  input  logic [RECTBITS:0]   hw__addr,
  input  logic [31:0]         hw__data,
  input  logic                hw__commit,
  output logic                hw__commit_ready,
  input  logic                vg__vblank,
  output logic [RECTBITS:0]   vg__addr,
  output logic [31:0]         st__data,
  output logic                vg__rect_write,
  output logic                ld__busy
`ifdef VGA_LOADER_STATS_EN
  ,
  output logic [15:0]         ld__commits
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_DRAIN} state_t;

  localparam logic [DEPTHBITS:0] C_FULL = (DEPTHBITS+1)'(DEPTH);
  localparam logic [DEPTHBITS:0] C_ONE  = (DEPTHBITS+1)'(1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [RECTBITS+32:0]      r_mem [DEPTH];
  logic [DEPTHBITS-1:0]      r_wr_ptr;
  logic [DEPTHBITS-1:0]      r_rd_ptr;
  logic [DEPTHBITS:0]        r_count;
  logic [DEPTHBITS:0]        r_batch_left;
  logic [RECTBITS:0]         r_addr;
  logic [31:0]               r_data;
  logic                      r_rect_write;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_commit_take;
  logic [DEPTHBITS:0]        w_commit_cnt;

  assign hw__ready        = (r_count != C_FULL);
  assign w_push           = hw__valid && hw__ready;
  assign w_commit_cnt     = r_count + {{DEPTHBITS{1'b0}}, w_push};
  assign hw__commit_ready = (r_state == S_IDLE);
  assign ld__busy         = (r_state != S_IDLE);
  assign vg__addr         = r_addr;
  assign st__data         = r_data;
  assign vg__rect_write   = r_rect_write;

  // A vblank cycle in PENDING already pops, so every blanking cycle carries one write.
  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_commit_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hw__commit && (w_commit_cnt != '0)) begin
          w_commit_take = 1'b1;
          w_state_next  = S_PENDING;
        end
      end
      S_PENDING, S_DRAIN: begin
        if (vg__vblank) begin
          w_pop        = 1'b1;
          w_state_next = (r_batch_left == C_ONE) ? S_IDLE : S_DRAIN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_batch_left <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rect_write <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rect_write <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + 1'b1;
        {r_addr, r_data}   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      // Entries pushed after the commit are not part of this batch count.
      if (w_commit_take)  r_batch_left <= w_commit_cnt;
      else if (w_pop)     r_batch_left <= r_batch_left - C_ONE;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {hw__addr, hw__data};
  end

`ifdef VGA_LOADER_STATS_EN
  logic [15:0] r_commits;
  assign ld__commits = r_commits;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                                  r_commits <= '0;
    else if (w_pop && (r_batch_left == C_ONE))   r_commits <= r_commits + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_rect_loader.sv
// Randomized and directed checks of vga_rect_loader against a queue-based batch model.
module tb_vga_rect_loader;
  localparam int RECTBITS  = 6;
  localparam int DEPTH     = 8;
  localparam int DEPTHBITS = 3;
  localparam int AW        = RECTBITS + 1;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          hw__valid;
  logic          hw__ready;
  logic [AW-1:0] hw__addr;
  logic [31:0]   hw__data;
  logic          hw__commit;
  logic          hw__commit_ready;
  logic          vg__vblank;
  logic [AW-1:0] vg__addr;
  logic [31:0]   st__data;
  logic          vg__rect_write;
  logic          ld__busy;
`ifdef VGA_LOADER_STATS_EN
  logic [15:0]   ld__commits;
`endif

  always #5 clk = ~clk;

  vga_rect_loader #(.RECTBITS(RECTBITS), .DEPTH(DEPTH), .DEPTHBITS(DEPTHBITS)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .hw__valid        (hw__valid),
    .hw__ready        (hw__ready),
    .hw__addr         (hw__addr),
    .hw__data         (hw__data),
    .hw__commit       (hw__commit),
    .hw__commit_ready (hw__commit_ready),
    .vg__vblank       (vg__vblank),
    .vg__addr         (vg__addr),
    .st__data         (st__data),
    .vg__rect_write   (vg__rect_write),
    .ld__busy         (ld__busy)
`ifdef VGA_LOADER_STATS_EN
    ,
    .ld__commits      (ld__commits)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: FIFO contents as a queue, a batch as "busy with N entries left".
  logic [AW+31:0] m_q[$];
  logic           m_busy;
  int             m_left;
  logic           m_rw;
  logic [AW-1:0]  m_addr;
  logic [31:0]    m_data;
  int             m_commits;
  int             n_strobe;
  logic [AW+34:0] got_q[$];
  logic [AW+34:0] exp_q[$];

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0; m_left = 0; m_rw = 1'b0;
    m_addr = '0; m_data = '0; m_commits = 0;
    n_strobe = 0;
    got_q.delete(); exp_q.delete();
  endtask

  // One clock; advances the model by the same rules and logs both views of the cycle.
  task automatic tick();
    logic push, pop, commit, m_ready;
    int n;
    logic [AW+31:0] e;
    push   = hw__valid && (m_q.size() < DEPTH);
    pop    = m_busy && vg__vblank;
    commit = hw__commit && !m_busy;
    n      = m_q.size() + (push ? 1 : 0);
    e      = {hw__addr, hw__data};
    @(posedge clk); #1;
    m_rw = 1'b0;
    if (pop) begin
      {m_addr, m_data} = m_q.pop_front();
      m_rw = 1'b1;
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_commits++;
      end
    end
    if (push) m_q.push_back(e);
    if (commit && n > 0) begin
      m_busy = 1'b1;
      m_left = n;
    end
    m_ready = (m_q.size() < DEPTH);
    if (vg__rect_write) n_strobe++;
    got_q.push_back({ld__busy, hw__ready, vg__rect_write, vg__addr, st__data});
    exp_q.push_back({m_busy, m_ready, m_rw, m_addr, m_data});
  endtask

  task automatic do_reset();
    hw__valid = 1'b0; hw__commit = 1'b0; vg__vblank = 1'b0;
    hw__addr = '0; hw__data = '0;
    rst_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d);
    hw__valid = 1'b1; hw__addr = a; hw__data = d;
    tick();
    hw__valid = 1'b0;
  endtask

  task automatic test_reset();
    hw__valid = 1'b0; hw__commit = 1'b0; vg__vblank = 1'b0;
    hw__addr = '0; hw__data = '0;
    rst_b = 1'b0;
    #3;
    total++; if (vg__rect_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", vg__rect_write); end
    total++; if (vg__addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", vg__addr); end
    total++; if (st__data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", st__data); end
    total++; if (ld__busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ld__busy); end
    total++; if (hw__ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", hw__ready); end
    total++; if (hw__commit_ready !== 1'b1) begin bad++; $display("FAIL reset_commit_ready got=%b want=1", hw__commit_ready); end
`ifdef VGA_LOADER_STATS_EN
    total++; if (ld__commits !== 16'd0) begin bad++; $display("FAIL reset_commits got=%0d want=0", ld__commits); end
`endif
    do_reset();
    $display("test_reset: checks so far total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_basic_batch();
    do_reset();
    push_word(7'h02, 32'h00640032);
    push_word(7'h03, 32'h00C80096);
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    total++; if (ld__busy !== 1'b1) begin bad++; $display("FAIL basic_pending_busy got=%b want=1", ld__busy); end
    tick();
    total++; if (vg__rect_write !== 1'b0) begin bad++; $display("FAIL basic_no_strobe got=%b want=0", vg__rect_write); end
    vg__vblank = 1'b1;
    tick();
    total++; if ({vg__rect_write, vg__addr, st__data} !== {1'b1, 7'h02, 32'h00640032}) begin
      bad++; $display("FAIL basic_first got=%b/%h/%h want=1/02/00640032", vg__rect_write, vg__addr, st__data); end
    tick();
    total++; if ({vg__rect_write, vg__addr, st__data} !== {1'b1, 7'h03, 32'h00C80096}) begin
      bad++; $display("FAIL basic_second got=%b/%h/%h want=1/03/00c80096", vg__rect_write, vg__addr, st__data); end
    total++; if (ld__busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", ld__busy); end
    tick();
    total++; if ({vg__rect_write, vg__addr, st__data} !== {1'b0, 7'h03, 32'h00C80096}) begin
      bad++; $display("FAIL basic_hold got=%b/%h/%h want=0/03/00c80096", vg__rect_write, vg__addr, st__data); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_basic_batch: strobes=%0d", n_strobe);
  endtask

  task automatic test_full_fifo();
    int cyc;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      push_word(7'(k + 16), $urandom);
      if (k == 7) begin
        total++; if (hw__ready !== 1'b0) begin bad++; $display("FAIL full_ready8 got=%b want=0", hw__ready); end
      end
      if (k == 8) begin
        total++; if (hw__ready !== 1'b0) begin bad++; $display("FAIL full_ready9 got=%b want=0", hw__ready); end
      end
    end
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    vg__vblank = 1'b1;
    cyc = 0;
    while ((ld__busy || m_busy) && cyc < 40) begin tick(); cyc++; end
    total++; if (cyc >= 40) begin bad++; $display("FAIL full_timeout got=%0d want<40", cyc); end
    total++; if (n_strobe !== 8) begin bad++; $display("FAIL full_strobes got=%0d want=8", n_strobe); end
    total++; if (vg__addr !== 7'd23) begin bad++; $display("FAIL full_last_addr got=%h want=17", vg__addr); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_full_fifo: strobes=%0d", n_strobe);
  endtask

  task automatic test_pause();
    do_reset();
    for (int k = 0; k < 5; k++) push_word(7'($urandom), $urandom);
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    vg__vblank = 1'b1; repeat (2) tick();
    total++; if (n_strobe !== 2) begin bad++; $display("FAIL pause_first got=%0d want=2", n_strobe); end
    vg__vblank = 1'b0; repeat (10) tick();
    total++; if (n_strobe !== 2) begin bad++; $display("FAIL pause_low got=%0d want=2", n_strobe); end
    total++; if (ld__busy !== 1'b1) begin bad++; $display("FAIL pause_busy got=%b want=1", ld__busy); end
    vg__vblank = 1'b1; repeat (3) tick();
    total++; if (n_strobe !== 5) begin bad++; $display("FAIL pause_total got=%0d want=5", n_strobe); end
    total++; if (ld__busy !== 1'b0) begin bad++; $display("FAIL pause_done got=%b want=0", ld__busy); end
    tick();
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL pause_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_pause: strobes=%0d", n_strobe);
  endtask

  task automatic test_commit_corners();
    do_reset();
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    total++; if (ld__busy !== 1'b0) begin bad++; $display("FAIL empty_commit_busy got=%b want=0", ld__busy); end
    vg__vblank = 1'b1; repeat (3) tick();
    total++; if (n_strobe !== 0) begin bad++; $display("FAIL empty_commit_strobes got=%0d want=0", n_strobe); end
`ifdef VGA_LOADER_STATS_EN
    total++; if (ld__commits !== 16'd0) begin bad++; $display("FAIL empty_commit_stats got=%0d want=0", ld__commits); end
`endif
    vg__vblank = 1'b0;
    hw__valid = 1'b1; hw__commit = 1'b1; hw__addr = 7'h55; hw__data = 32'hCAFE1234;
    tick();
    hw__valid = 1'b0; hw__commit = 1'b0;
    total++; if (ld__busy !== 1'b1) begin bad++; $display("FAIL same_cycle_busy got=%b want=1", ld__busy); end
    vg__vblank = 1'b1; tick();
    total++; if ({vg__rect_write, vg__addr, st__data} !== {1'b1, 7'h55, 32'hCAFE1234}) begin
      bad++; $display("FAIL same_cycle_strobe got=%b/%h/%h want=1/55/cafe1234", vg__rect_write, vg__addr, st__data); end
    repeat (2) tick();
    total++; if (n_strobe !== 1) begin bad++; $display("FAIL same_cycle_count got=%0d want=1", n_strobe); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL corner_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_commit_corners: strobes=%0d", n_strobe);
  endtask

  task automatic test_mid_drain();
    int cyc;
    do_reset();
    for (int k = 0; k < 3; k++) push_word(7'(k + 1), 32'h1000 + k);
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    vg__vblank = 1'b1;
    tick();
    hw__valid = 1'b1; hw__addr = 7'h44; hw__data = 32'hD0D0; tick();
    hw__addr = 7'h45; hw__data = 32'hE0E0; hw__commit = 1'b1; tick();
    hw__valid = 1'b0; hw__commit = 1'b0;
    repeat (5) tick();
    total++; if (n_strobe !== 3) begin bad++; $display("FAIL mid_strobes got=%0d want=3", n_strobe); end
    total++; if (ld__busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", ld__busy); end
    total++; if (vg__addr !== 7'h03) begin bad++; $display("FAIL mid_last_addr got=%h want=03", vg__addr); end
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    cyc = 0;
    while ((ld__busy || m_busy) && cyc < 20) begin tick(); cyc++; end
    total++; if (cyc >= 20) begin bad++; $display("FAIL mid_timeout got=%0d want<20", cyc); end
    total++; if ({n_strobe, vg__addr, st__data} !== {32'd5, 7'h45, 32'hE0E0}) begin
      bad++; $display("FAIL mid_second_batch got=%0d/%h/%h want=5/45/0000e0e0", n_strobe, vg__addr, st__data); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_mid_drain: strobes=%0d", n_strobe);
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int k = 0; k < 4; k++) push_word(7'(k + 8), 32'hABC0 + k);
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    vg__vblank = 1'b1; tick();
    total++; if (vg__rect_write !== 1'b1) begin bad++; $display("FAIL rstmid_first got=%b want=1", vg__rect_write); end
    #1 rst_b = 1'b0;
    #1;
    total++; if ({vg__rect_write, vg__addr, st__data, ld__busy} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%b/%h/%h/%b want=0/0/0/0", vg__rect_write, vg__addr, st__data, ld__busy); end
    model_reset();
    @(posedge clk); #1 rst_b = 1'b1;
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    repeat (4) tick();
    total++; if (n_strobe !== 0) begin bad++; $display("FAIL rstmid_strobes got=%0d want=0", n_strobe); end
    total++; if (ld__busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", ld__busy); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_reset_mid_drain: strobes=%0d", n_strobe);
  endtask

  task automatic test_stats();
    int cyc;
    do_reset();
    hw__commit = 1'b1; tick(); hw__commit = 1'b0;
    for (int b = 0; b < 3; b++) begin
      vg__vblank = 1'b0;
      for (int k = 0; k <= b; k++) push_word(7'($urandom), $urandom);
      hw__commit = 1'b1; tick(); hw__commit = 1'b0;
      vg__vblank = 1'b1;
      cyc = 0;
      while ((ld__busy || m_busy) && cyc < 20) begin tick(); cyc++; end
      total++; if (cyc >= 20) begin bad++; $display("FAIL stats_timeout%0d got=%0d want<20", b, cyc); end
    end
`ifdef VGA_LOADER_STATS_EN
    total++; if (ld__commits !== 16'd3) begin bad++; $display("FAIL stats_commits got=%0d want=3", ld__commits); end
`endif
    total++; if (n_strobe !== 6) begin bad++; $display("FAIL stats_strobes got=%0d want=6", n_strobe); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stats_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_stats: strobes=%0d batches=%0d", n_strobe, m_commits);
  endtask

  task automatic test_random();
    int cyc;
    int npush;
    do_reset();
    for (int r = 0; r < 12; r++) begin
      npush = $urandom_range(0, 9);
      for (int k = 0; k < npush; k++) begin
        hw__valid = ($urandom % 4) != 0;
        hw__addr = 7'($urandom); hw__data = $urandom;
        vg__vblank = $urandom % 2;
        tick();
      end
      hw__valid = $urandom % 2; hw__addr = 7'($urandom); hw__data = $urandom;
      hw__commit = 1'b1; tick(); hw__commit = 1'b0; hw__valid = 1'b0;
      cyc = 0;
      while ((ld__busy || m_busy) && cyc < 300) begin
        vg__vblank = ($urandom % 3) != 0;
        hw__valid  = ($urandom % 4) == 0;
        hw__addr   = 7'($urandom); hw__data = $urandom;
        hw__commit = ($urandom % 8) == 0;
        tick();
        cyc++;
      end
      hw__valid = 1'b0; hw__commit = 1'b0;
      total++; if (cyc >= 300) begin bad++; $display("FAIL rand_timeout%0d got=%0d want<300", r, cyc); end
`ifdef VGA_LOADER_STATS_EN
      total++; if (ld__commits !== 16'(m_commits)) begin bad++; $display("FAIL rand_commits%0d got=%0d want=%0d", r, ld__commits, m_commits); end
`endif
    end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_cycle%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test_random: cycles=%0d strobes=%0d batches=%0d", got_q.size(), n_strobe, m_commits);
  endtask

  initial begin
    test_reset();
    test_basic_batch();
    test_full_fifo();
    test_pause();
    test_commit_corners();
    test_mid_drain();
    test_reset_mid_drain();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_rect_loader.md
Name: vga_rect_loader

Overview:
- Host-side write scheduler for the rectangle stage of the VGA pipeline.
- Buffers rectangle-configuration writes from the host in a small FIFO, where the host closes each batch with a commit pulse.
- Replays each committed batch onto the pipeline's rectangle-write port (vg__addr / st__data / vg__rect_write) only while vertical blanking is active, so rectangle geometry never changes mid-frame.
- Sits between the host register interface and vga_pipeline; its outputs connect directly to the pipeline's write inputs.

Parameters:
- RECTBITS, 6, rectangle index width; write address is RECTBITS+1 bits (index plus word select in bit 0).
- DEPTH, 8, FIFO entries; must be a power of two.
- DEPTHBITS, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst_b  input  1  asynchronous active-low reset.
- hw__valid  input  1  host write request.
- hw__ready  output  1  FIFO can accept; equals !full, decoded from registered count.
- hw__addr  input  RECTBITS+1  host write address.
- hw__data  input  32  host write data.
- hw__commit  input  1  single-cycle pulse that closes the current batch.
- hw__commit_ready  output  1  high only in IDLE; commits are ignored otherwise.
- vg__vblank  input  1  level, high during vertical blanking.
- vg__addr  output  RECTBITS+1  registered write address to the pipeline.
- st__data  output  32  registered write data to the pipeline.
- vg__rect_write  output  1  registered write strobe to the pipeline.
- ld__busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst_b is asynchronous, active-low.
  - Reset values: state=IDLE, FIFO count/pointers=0, batch_left=0, vg__addr=0, st__data=0, vg__rect_write=0, ld__busy=0.
  - Reset mid-drain discards all FIFO contents and the remaining batch; no further strobes are issued.
- FIFO:
  - A push occurs when hw__valid && hw__ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full: count==DEPTH, hw__ready=0, and hw__valid is ignored (no overwrite).
  - Pointers wrap modulo DEPTH.
- State IDLE:
  - hw__commit_ready=1.
  - On hw__commit, batch_left <= count including any same-cycle push.
  - If that value is 0, the commit is a no-op and the state stays IDLE; otherwise go to PENDING.
- State PENDING:
  - Wait for vg__vblank==1 (level, not edge), then go to DRAIN.
  - If vblank is already high in the cycle after the commit, drain starts that cycle.
- State DRAIN:
  - Each cycle with vg__vblank==1: pop the head, register its addr/data onto vg__addr/st__data, assert vg__rect_write for that one cycle, and decrement batch_left.
  - Throughput is one write per cycle; strobe latency is 1 cycle from the pop decision.
  - When the last entry is popped (batch_left==1 at pop), go to IDLE.
  - vg__rect_write drops on the following cycle unless it is still carrying that last write.
- Vblank falling mid-drain:
  - Pause: no pop, vg__rect_write=0, and batch_left is held.
  - Resume at the next vblank. The batch completes over more than one blanking period and is never aborted.
- Batch boundaries:
  - Entries pushed after a commit (including during PENDING/DRAIN) belong to the next batch.
  - Those entries are never drained by the current batch; the FIFO holds them behind the batch's entries.
- Output hold:
  - vg__addr/st__data keep their last values when no strobe is active.
  - vg__rect_write is 0 whenever no entry was popped in the previous cycle.
- Stall: vg__stall from the pipeline is not consulted; rectangle writes are legal while stalled.

Optional Feature:
- Macro: VGA_LOADER_STATS_EN.
- Defined: adds output ld__commits [15:0], reset 0.
  - Increments by 1 in the cycle DRAIN→IDLE occurs (batch fully written) and wraps 0xFFFF→0.
  - No-op commits do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic batch:
  - Reset, vblank=0; push (addr 0x02, data 0x00640032) and (0x03, 0x00C80096); commit.
  - Expect state PENDING and no strobe.
  - Raise vblank: expect two consecutive strobes, 0x02/0x00640032 then 0x03/0x00C80096; ld__busy falls after the second.
- Full FIFO:
  - Push 9 words with DEPTH=8 and no commit.
  - Expect hw__ready=0 after the 8th; the 9th is not accepted; count stays 8.
- Pause across frames:
  - Commit 5 entries; vblank high for 2 cycles, low for 10, then high.
  - Expect 2 strobes, none during the low period, then the remaining 3; order preserved.
- Commit corner cases:
  - Commit with the FIFO empty: expect IDLE, no strobe, ld__commits unchanged.
  - Commit in the same cycle as a single push: expect batch of 1, one strobe at the next vblank.
- Mid-drain traffic:
  - Commit 3 entries; during DRAIN push 2 more and pulse commit.
  - Expect exactly 3 strobes and return to IDLE with count=2; the ignored commit causes no drain.
  - A new commit then drains the 2 entries.
- Reset and stats:
  - Assert rst_b low after the 1st strobe of a 4-entry batch: expect all outputs 0 immediately and count=0.
  - With VGA_LOADER_STATS_EN, after 3 completed batches expect ld__commits=3.
